uart_bus_master: RTL and testbench

//   Bus initiator driven by a UART byte stream (host debug bridge).
//   - Decodes command frames from the uart_rx byte output.
//   - Issues single read/write cycles on the chip-select/word bus that memory-mapped peripherals answer.
//   - Returns read data or an ACK as bytes through a valid/ready handshake toward a tx fifo / uart_tx.
//

---
 rtl/uart_bus_master.sv | 97 +++++++++
 tb/tb_uart_bus_master.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_master.sv
// uart_bus_master: decodes UART command frames into single read/write cycles on a chip-select bus.
// Optional feature macro UART_BUS_MASTER_ERR_EN: invalid commands are answered with NAK_BYTE.
module uart_bus_master #(
   parameter logic [23:0] TIMEOUT  = 24'd5_000_000,
   parameter logic [7:0]  ACK_BYTE = 8'hA5,
   parameter logic [7:0]  NAK_BYTE = 8'h5A
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic [7:0]  rx_data_i,
   input  logic        rx_valid_i,
   output logic [7:0]  tx_data_o,
   output logic        tx_valid_o,
   input  logic        tx_ready_i,
   output logic        chip_select_o,
   output logic [31:0] addr_o,
   output logic        read_enable_o,
   input  logic [31:0] read_data_i,
   output logic [31:0] write_data_o,
   output logic [3:0]  write_mask_o,
   output logic        busy_o
);
   typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS_WR, BUS_RD, RD_WAIT, RESP, ERR} state_t;
   state_t      r_state, w_next;
   logic        r_wr;
   logic [3:0]  r_mask;
   logic [1:0]  r_cnt;
   logic [23:0] r_to;
   logic [31:0] r_addr, r_wdata, r_rdata;
   logic        w_cmd_ok, w_collect, w_timeout, w_tx_hs, w_last;
   assign w_cmd_ok  = rx_data_i[6:4] == 3'b000;
   assign w_collect = r_state == ADDR || r_state == DATA;
   assign w_timeout = w_collect && !rx_valid_i && r_to == TIMEOUT - 24'd1;
   assign w_tx_hs   = tx_valid_o && tx_ready_i;
   assign w_last    = r_wr || r_cnt == 2'd3;
   assign addr_o       = r_addr;
   assign write_data_o = r_wdata;
   always_ff @(posedge clk_i) begin
      if (reset_i) r_state <= IDLE;
      else r_state <= w_next;
   end
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (rx_valid_i) begin
`ifdef UART_BUS_MASTER_ERR_EN
               w_next = w_cmd_ok ? ADDR : ERR;
`else
               w_next = w_cmd_ok ? ADDR : IDLE;
`endif
            end
         end
         ADDR:    w_next = w_timeout ? IDLE : (rx_valid_i && r_cnt == 2'd3) ? (r_wr ? DATA : BUS_RD) : ADDR;
         DATA:    w_next = w_timeout ? IDLE : (rx_valid_i && r_cnt == 2'd3) ? BUS_WR : DATA;
         BUS_WR:  w_next = RESP;
         BUS_RD:  w_next = RD_WAIT;
         RD_WAIT: w_next = RESP;
         RESP:    w_next = (w_tx_hs && w_last) ? IDLE : RESP;
         ERR:     w_next = w_tx_hs ? IDLE : ERR;
         default: w_next = IDLE;
      endcase
   end
   // A zero write mask still passes through BUS_WR so the ACK timing is unchanged.
   always_comb begin
      chip_select_o = (r_state == BUS_WR && |r_mask) || r_state == BUS_RD;
      read_enable_o = r_state == BUS_RD;
      write_mask_o  = r_state == BUS_WR ? r_mask : 4'h0;
      tx_valid_o    = r_state == RESP || r_state == ERR;
      tx_data_o     = r_state == ERR ? NAK_BYTE : r_state != RESP ? 8'h00 :
                      r_wr ? ACK_BYTE : r_rdata[{r_cnt, 3'b000} +: 8];
      busy_o        = r_state != IDLE;
   end
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_wr    <= 1'b0;
         r_mask  <= 4'h0;
         r_cnt   <= 2'd0;
         r_to    <= 24'd0;
         r_addr  <= 32'h0;
         r_wdata <= 32'h0;
         r_rdata <= 32'h0;
      end else begin
         r_to <= (rx_valid_i || !w_collect) ? 24'd0 : r_to + 24'd1;
         if (r_state == IDLE && rx_valid_i) begin
            r_wr   <= rx_data_i[7];
            r_mask <= rx_data_i[3:0];
         end
         if (r_state == ADDR && rx_valid_i) r_addr <= {rx_data_i, r_addr[31:8]};
         if (r_state == DATA && rx_valid_i) r_wdata <= {rx_data_i, r_wdata[31:8]};
         if (r_state == RD_WAIT) r_rdata <= read_data_i;
         // The 2-bit counter wraps to 0 after each 4-byte field, ready for the next one.
         if (r_state == IDLE && rx_valid_i) r_cnt <= 2'd0;
         else if ((w_collect && rx_valid_i) || (r_state == RESP && w_tx_hs)) r_cnt <= r_cnt + 2'd1;
      end
   end
endmodule

// File: tb/tb_uart_bus_master.sv
// tb_uart_bus_master: scoreboard bench for uart_bus_master with TIMEOUT shortened to 100 cycles.
// Observations are gathered 1ns after each rising edge; scenario tasks compare them with expectations.
`timescale 1ns/1ps
module tb_uart_bus_master;
   localparam logic [23:0] TO = 24'd100;
   logic        clk_i = 1'b0;
   logic        reset_i = 1'b1;
   logic [7:0]  rx_data_i = 8'h00;
   logic        rx_valid_i = 1'b0;
   logic [7:0]  tx_data_o;
   logic        tx_valid_o;
   logic        tx_ready_i = 1'b1;
   logic        chip_select_o;
   logic [31:0] addr_o;
   logic        read_enable_o;
   logic [31:0] read_data_i = 32'h0;
   logic [31:0] write_data_o;
   logic [3:0]  write_mask_o;
   logic        busy_o;

   typedef struct {logic [31:0] a; logic [31:0] d; logic [3:0] m; logic re; int cyc;} bus_t;
   typedef struct {logic [7:0] b; logic busy;} tx_t;
   bus_t       exp_bus[$], obs_bus[$];
   logic [7:0] exp_tx[$];
   tx_t        obs_tx[$];
   int         obs_txv[$];
   int         checks = 0, failures = 0;
   int         cyc = 0, last_rx_cyc = 0, stab_err = 0, m_wc = 0;
   bit         stall = 1'b0;
   logic       m_pv = 1'b0, m_pr = 1'b0, m_rd = 1'b0;
   logic [7:0] m_pd = 8'h00;
   logic [31:0] rd_val = 32'h0;

   uart_bus_master #(.TIMEOUT(TO)) dut (
      .clk_i(clk_i), .reset_i(reset_i), .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
      .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
      .chip_select_o(chip_select_o), .addr_o(addr_o), .read_enable_o(read_enable_o),
      .read_data_i(read_data_i), .write_data_o(write_data_o), .write_mask_o(write_mask_o),
      .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   // Monitor: also plays the bus slave (read data only in the cycle after the strobe) and the tx sink.
   always @(posedge clk_i) begin
      #1;
      cyc++;
      read_data_i = m_rd ? rd_val : 32'hBAD0_0BAD;
      m_rd = chip_select_o && read_enable_o;
      if (rx_valid_i) last_rx_cyc = cyc - 1;
      if (chip_select_o) obs_bus.push_back('{addr_o, write_data_o, write_mask_o, read_enable_o, cyc});
      if (tx_valid_o && !m_pv) obs_txv.push_back(cyc);
      if (m_pv && !m_pr && (tx_valid_o !== 1'b1 || tx_data_o !== m_pd)) stab_err++;
      tx_ready_i = !stall || (tx_valid_o && m_wc >= 10);
      if (tx_valid_o && !tx_ready_i) m_wc++;
      if (tx_valid_o && tx_ready_i) begin
         obs_tx.push_back('{tx_data_o, busy_o});
         m_wc = 0;
      end
      m_pv = tx_valid_o;
      m_pr = tx_ready_i;
      m_pd = tx_data_o;
   end

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk_i);
      rx_valid_i = 1'b1;
      rx_data_i  = b;
      @(negedge clk_i);
      rx_valid_i = 1'b0;
   endtask

   task automatic send_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
      send_byte({4'h8, m});
      for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
      for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
      if (m != 4'h0) exp_bus.push_back('{a, d, m, 1'b0, 0});
      exp_tx.push_back(8'hA5);
   endtask

   task automatic send_read(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] d);
      rd_val = d;
      send_byte(cmd);
      for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
      exp_bus.push_back('{a, 32'h0, 4'h0, 1'b1, 0});
      for (int i = 0; i < 4; i++) exp_tx.push_back(d[8*i +: 8]);
   endtask

   task automatic wait_tx(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk_i);
         if (obs_tx.size() >= exp_tx.size()) begin
            ok = 1'b1;
            break;
         end
      end
      repeat (3) @(negedge clk_i);
   endtask

   task automatic test_reset();
      reset_i = 1'b1;
      repeat (3) @(negedge clk_i);
      checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy_o); end
      checks++; if (tx_valid_o !== 1'b0) begin failures++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid_o); end
      checks++; if (tx_data_o !== 8'h00) begin failures++; $display("FAIL reset_tx_data: got %h want 00", tx_data_o); end
      checks++; if (chip_select_o !== 1'b0 || read_enable_o !== 1'b0) begin failures++; $display("FAIL reset_strobes: cs=%b re=%b want 0 0", chip_select_o, read_enable_o); end
      checks++; if (addr_o !== 32'h0 || write_data_o !== 32'h0 || write_mask_o !== 4'h0) begin failures++; $display("FAIL reset_bus: addr=%h wdata=%h mask=%h want zeros", addr_o, write_data_o, write_mask_o); end
      reset_i = 1'b0;
      obs_bus.delete(); obs_tx.delete(); obs_txv.delete();
   endtask

   task automatic test_write();
      bus_t eb, ob;
      tx_t ot;
      logic [7:0] et;
      bit ok;
      int bcyc = -100;
      obs_txv.delete();
      send_write(32'h2000_0010, 32'hDEAD_BEEF, 4'hF);
      wait_tx(ok);
      checks++; if (!ok) begin failures++; $display("FAIL write_wait: tx seen %0d want %0d", obs_tx.size(), exp_tx.size()); end
      while (exp_bus.size() > 0) begin
         eb = exp_bus.pop_front();
         checks++;
         if (obs_bus.size() == 0) begin failures++; $display("FAIL write_bus: no bus cycle, want addr=%h", eb.a); end
         else begin
            ob = obs_bus.pop_front();
            bcyc = ob.cyc;
            if (ob.a !== eb.a || ob.d !== eb.d || ob.m !== eb.m || ob.re !== eb.re) begin failures++; $display("FAIL write_bus: got a=%h d=%h m=%h re=%b want a=%h d=%h m=%h re=%b", ob.a, ob.d, ob.m, ob.re, eb.a, eb.d, eb.m, eb.re); end
         end
      end
      checks++; if (obs_bus.size() != 0) begin failures++; $display("FAIL write_extra_bus: %0d extra cycles want 0", obs_bus.size()); end
      while (exp_tx.size() > 0) begin
         et = exp_tx.pop_front();
         checks++;
         if (obs_tx.size() == 0) begin failures++; $display("FAIL write_tx: missing byte want %h", et); end
         else begin ot = obs_tx.pop_front(); if (ot.b !== et) begin failures++; $display("FAIL write_tx: got %h want %h", ot.b, et); end end
      end
      checks++; if (obs_tx.size() != 0) begin failures++; $display("FAIL write_extra_tx: %0d extra bytes want 0", obs_tx.size()); end
      checks++; if (bcyc - last_rx_cyc !== 1) begin failures++; $display("FAIL write_cs_latency: got %0d want 1", bcyc - last_rx_cyc); end
      checks++; if (obs_txv.size() == 0 || obs_txv[0] - bcyc !== 1) begin failures++; $display("FAIL write_ack_latency: got %0d want 1", obs_txv.size() == 0 ? -1 : obs_txv[0] - bcyc); end
      obs_bus.delete(); obs_tx.delete();
   endtask

   task automatic test_read();
      bus_t eb, ob;
      tx_t ot;
      logic [7:0] et;
      bit ok;
      int bcyc = -100;
      obs_txv.delete();
      send_read(8'h00, 32'h2000_0004, 32'h1234_5678);
      wait_tx(ok);
      checks++; if (!ok) begin failures++; $display("FAIL read_wait: tx seen %0d want %0d", obs_tx.size(), exp_tx.size()); end
      while (exp_bus.size() > 0) begin
         eb = exp_bus.pop_front();
         checks++;
         if (obs_bus.size() == 0) begin failures++; $display("FAIL read_bus: no bus cycle, want addr=%h", eb.a); end
         else begin
            ob = obs_bus.pop_front();
            bcyc = ob.cyc;
            if (ob.a !== eb.a || ob.m !== eb.m || ob.re !== eb.re) begin failures++; $display("FAIL read_bus: got a=%h m=%h re=%b want a=%h m=%h re=%b", ob.a, ob.m, ob.re, eb.a, eb.m, eb.re); end
         end
      end
      checks++; if (obs_bus.size() != 0) begin failures++; $display("FAIL read_extra_bus: %0d extra cycles want 0", obs_bus.size()); end
      while (exp_tx.size() > 0) begin
         et = exp_tx.pop_front();
         checks++;
         if (obs_tx.size() == 0) begin failures++; $display("FAIL read_tx: missing byte want %h", et); end
         else begin ot = obs_tx.pop_front(); if (ot.b !== et) begin failures++; $display("FAIL read_tx: got %h want %h", ot.b, et); end end
      end
      checks++; if (obs_tx.size() != 0) begin failures++; $display("FAIL read_extra_tx: %0d extra bytes want 0", obs_tx.size()); end
      checks++; if (bcyc - last_rx_cyc !== 1) begin failures++; $display("FAIL read_cs_latency: got %0d want 1", bcyc - last_rx_cyc); end
      checks++; if (obs_txv.size() == 0 || obs_txv[0] - bcyc !== 2) begin failures++; $display("FAIL read_tx_latency: got %0d want 2", obs_txv.size() == 0 ? -1 : obs_txv[0] - bcyc); end
      obs_bus.delete(); obs_tx.delete();
   endtask

   task automatic test_read_stall();
      bus_t eb, ob;
      tx_t ot;
      logic [7:0] et;
      bit ok;
      stall = 1'b1;
      send_read(8'h00, 32'h2000_0004, 32'h1234_5678);
      repeat (4) @(negedge clk_i);
      send_byte(8'h8F);
      wait_tx(ok);
      stall = 1'b0;
      checks++; if (!ok) begin failures++; $display("FAIL stall_wait: tx seen %0d want %0d", obs_tx.size(), exp_tx.size()); end
      while (exp_bus.size() > 0) begin
         eb = exp_bus.pop_front();
         checks++;
         if (obs_bus.size() == 0) begin failures++; $display("FAIL stall_bus: no bus cycle, want addr=%h", eb.a); end
         else begin
            ob = obs_bus.pop_front();
            if (ob.a !== eb.a || ob.m !== eb.m || ob.re !== eb.re) begin failures++; $display("FAIL stall_bus: got a=%h m=%h re=%b want a=%h m=%h re=%b", ob.a, ob.m, ob.re, eb.a, eb.m, eb.re); end
         end
      end
      checks++; if (obs_bus.size() != 0) begin failures++; $display("FAIL stall_extra_bus: %0d extra cycles want 0", obs_bus.size()); end
      while (exp_tx.size() > 0) begin
         et = exp_tx.pop_front();
         checks++;
         if (obs_tx.size() == 0) begin failures++; $display("FAIL stall_tx: missing byte want %h", et); end
         else begin
            ot = obs_tx.pop_front();
            if (ot.b !== et || ot.busy !== 1'b1) begin failures++; $display("FAIL stall_tx: got %h busy=%b want %h busy=1", ot.b, ot.busy, et); end
         end
      end
      checks++; if (obs_tx.size() != 0) begin failures++; $display("FAIL stall_extra_tx: %0d extra bytes want 0", obs_tx.size()); end
      checks++; if (stab_err !== 0) begin failures++; $display("FAIL stall_stable: %0d unstable tx cycles want 0", stab_err); end
      checks++; if (busy_o !== 1'b0 || tx_valid_o !== 1'b0) begin failures++; $display("FAIL stall_idle: busy=%b tx_valid=%b want 0 0", busy_o, tx_valid_o); end
      obs_bus.delete(); obs_tx.delete();
   endtask

   task automatic test_timeout();
      bus_t eb, ob;
      tx_t ot;
      logic [7:0] et;
      bit ok;
      send_byte(8'h8F);
      send_byte(8'h10);
      repeat (90) @(negedge clk_i);
      checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL timeout_early: busy=%b want 1", busy_o); end
      repeat (11) @(negedge clk_i);
      checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL timeout_idle: busy=%b want 0", busy_o); end
      checks++; if (obs_bus.size() != 0 || obs_tx.size() != 0) begin failures++; $display("FAIL timeout_quiet: bus=%0d tx=%0d want 0 0", obs_bus.size(), obs_tx.size()); end
      send_write(32'h4000_0100, 32'h0BAD_F00D, 4'h5);
      wait_tx(ok);
      checks++; if (!ok) begin failures++; $display("FAIL timeout_wait: tx seen %0d want %0d", obs_tx.size(), exp_tx.size()); end
      while (exp_bus.size() > 0) begin
         eb = exp_bus.pop_front();
         checks++;
         if (obs_bus.size() == 0) begin failures++; $display("FAIL timeout_bus: no bus cycle, want addr=%h", eb.a); end
         else begin
            ob = obs_bus.pop_front();
            if (ob.a !== eb.a || ob.d !== eb.d || ob.m !== eb.m || ob.re !== eb.re) begin failures++; $display("FAIL timeout_bus: got a=%h d=%h m=%h re=%b want a=%h d=%h m=%h re=%b", ob.a, ob.d, ob.m, ob.re, eb.a, eb.d, eb.m, eb.re); end
         end
      end
      while (exp_tx.size() > 0) begin
         et = exp_tx.pop_front();
         checks++;
         if (obs_tx.size() == 0) begin failures++; $display("FAIL timeout_tx: missing byte want %h", et); end
         else begin ot = obs_tx.pop_front(); if (ot.b !== et) begin failures++; $display("FAIL timeout_tx: got %h want %h", ot.b, et); end end
      end
      checks++; if (obs_bus.size() != 0 || obs_tx.size() != 0) begin failures++; $display("FAIL timeout_extra: bus=%0d tx=%0d want 0 0", obs_bus.size(), obs_tx.size()); end
      obs_bus.delete(); obs_tx.delete();
   endtask

   task automatic test_invalid_cmd();
      bus_t eb, ob;
      tx_t ot;
      logic [7:0] et;
      bit ok;
      send_byte(8'h30);
`ifdef UART_BUS_MASTER_ERR_EN
      exp_tx.push_back(8'h5A);
`endif
      repeat (5) @(negedge clk_i);
      send_write(32'h2000_0010, 32'hDEAD_BEEF, 4'hF);
      wait_tx(ok);
      checks++; if (!ok) begin failures++; $display("FAIL invalid_wait: tx seen %0d want %0d", obs_tx.size(), exp_tx.size()); end
      while (exp_bus.size() > 0) begin
         eb = exp_bus.pop_front();
         checks++;
         if (obs_bus.size() == 0) begin failures++; $display("FAIL invalid_bus: no bus cycle, want addr=%h", eb.a); end
         else begin
            ob = obs_bus.pop_front();
            if (ob.a !== eb.a || ob.d !== eb.d || ob.m !== eb.m || ob.re !== eb.re) begin failures++; $display("FAIL invalid_bus: got a=%h d=%h m=%h re=%b want a=%h d=%h m=%h re=%b", ob.a, ob.d, ob.m, ob.re, eb.a, eb.d, eb.m, eb.re); end
         end
      end
      while (exp_tx.size() > 0) begin
         et = exp_tx.pop_front();
         checks++;
         if (obs_tx.size() == 0) begin failures++; $display("FAIL invalid_tx: missing byte want %h", et); end
         else begin ot = obs_tx.pop_front(); if (ot.b !== et) begin failures++; $display("FAIL invalid_tx: got %h want %h", ot.b, et); end end
      end
      checks++; if (obs_bus.size() != 0 || obs_tx.size() != 0) begin failures++; $display("FAIL invalid_extra: bus=%0d tx=%0d want 0 0", obs_bus.size(), obs_tx.size()); end
      obs_bus.delete(); obs_tx.delete();
   endtask

   task automatic test_reset_mid_frame();
      bus_t eb, ob;
      tx_t ot;
      logic [7:0] et;
      bit ok;
      send_byte(8'h00);
      send_byte(8'h04);
      send_byte(8'h00);
      send_byte(8'h00);
      reset_i = 1'b1;
      @(negedge clk_i);
      checks++; if (busy_o !== 1'b0 || tx_valid_o !== 1'b0 || chip_select_o !== 1'b0 || read_enable_o !== 1'b0) begin failures++; $display("FAIL midreset_ctrl: busy=%b txv=%b cs=%b re=%b want 0 0 0 0", busy_o, tx_valid_o, chip_select_o, read_enable_o); end
      checks++; if (addr_o !== 32'h0 || write_data_o !== 32'h0 || write_mask_o !== 4'h0 || tx_data_o !== 8'h00) begin failures++; $display("FAIL midreset_data: addr=%h wdata=%h mask=%h tx=%h want zeros", addr_o, write_data_o, write_mask_o, tx_data_o); end
      reset_i = 1'b0;
      obs_bus.delete(); obs_tx.delete();
      send_read(8'h00, 32'h2000_0004, 32'h1234_5678);
      wait_tx(ok);
      checks++; if (!ok) begin failures++; $display("FAIL midreset_wait: tx seen %0d want %0d", obs_tx.size(), exp_tx.size()); end
      while (exp_bus.size() > 0) begin
         eb = exp_bus.pop_front();
         checks++;
         if (obs_bus.size() == 0) begin failures++; $display("FAIL midreset_bus: no bus cycle, want addr=%h", eb.a); end
         else begin
            ob = obs_bus.pop_front();
            if (ob.a !== eb.a || ob.m !== eb.m || ob.re !== eb.re) begin failures++; $display("FAIL midreset_bus: got a=%h m=%h re=%b want a=%h m=%h re=%b", ob.a, ob.m, ob.re, eb.a, eb.m, eb.re); end
         end
      end
      while (exp_tx.size() > 0) begin
         et = exp_tx.pop_front();
         checks++;
         if (obs_tx.size() == 0) begin failures++; $display("FAIL midreset_tx: missing byte want %h", et); end
         else begin ot = obs_tx.pop_front(); if (ot.b !== et) begin failures++; $display("FAIL midreset_tx: got %h want %h", ot.b, et); end end
      end
      checks++; if (obs_bus.size() != 0 || obs_tx.size() != 0) begin failures++; $display("FAIL midreset_extra: bus=%0d tx=%0d want 0 0", obs_bus.size(), obs_tx.size()); end
      obs_bus.delete(); obs_tx.delete();
   endtask

   task automatic test_back_to_back();
      bus_t eb, ob;
      tx_t ot;
      logic [7:0] et;
      bit ok1, ok2, ok3;
      send_write(32'h1000_0008, 32'hCAFE_F00D, 4'h3);
      wait_tx(ok1);
      send_read(8'h0C, 32'h3000_00FC, 32'hA1B2_C3D4);
      wait_tx(ok2);
      send_write(32'h1000_000C, 32'h5555_AAAA, 4'h0);
      wait_tx(ok3);
      checks++; if (!(ok1 && ok2 && ok3)) begin failures++; $display("FAIL b2b_wait: done=%b%b%b want 111", ok1, ok2, ok3); end
      while (exp_bus.size() > 0) begin
         eb = exp_bus.pop_front();
         checks++;
         if (obs_bus.size() == 0) begin failures++; $display("FAIL b2b_bus: no bus cycle, want addr=%h", eb.a); end
         else begin
            ob = obs_bus.pop_front();
            if (ob.a !== eb.a || ob.m !== eb.m || ob.re !== eb.re || (!eb.re && ob.d !== eb.d)) begin failures++; $display("FAIL b2b_bus: got a=%h d=%h m=%h re=%b want a=%h d=%h m=%h re=%b", ob.a, ob.d, ob.m, ob.re, eb.a, eb.d, eb.m, eb.re); end
         end
      end
      checks++; if (obs_bus.size() != 0) begin failures++; $display("FAIL b2b_extra_bus: %0d extra cycles want 0", obs_bus.size()); end
      while (exp_tx.size() > 0) begin
         et = exp_tx.pop_front();
         checks++;
         if (obs_tx.size() == 0) begin failures++; $display("FAIL b2b_tx: missing byte want %h", et); end
         else begin ot = obs_tx.pop_front(); if (ot.b !== et) begin failures++; $display("FAIL b2b_tx: got %h want %h", ot.b, et); end end
      end
      checks++; if (obs_tx.size() != 0) begin failures++; $display("FAIL b2b_extra_tx: %0d extra bytes want 0", obs_tx.size()); end
      obs_bus.delete(); obs_tx.delete();
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_read_stall();
      test_timeout();
      test_invalid_cmd();
      test_reset_mid_frame();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
